// File: rtl/float_pkg.sv
// Shared float-unpack types, exponent bias helper and class-bit positions.
// Split layout is sized for the widest format; narrower formats use the low bits of each field.
package float_pkg;
  localparam int MAX_EXP_W = 15;
  localparam int MAX_SIG_W = 52;

  typedef struct packed {
    logic                 sign;
    logic [MAX_EXP_W-1:0] exponent;
    logic [MAX_SIG_W-1:0] significand;
  } float_split_t;

  // io_out_class bit positions: {nan, inf, subnormal, zero}
  localparam int CLS_ZERO = 0;
  localparam int CLS_SUB  = 1;
  localparam int CLS_INF  = 2;
  localparam int CLS_NAN  = 3;
  localparam int CLS_W    = 4;

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction
endpackage

// File: rtl/float_fields.sv
// Combinational split of a packed float into sign, exponent, hidden-bit mantissa and unbiased exponent.
// Zero latency, no flow control; class bits exist only with FLOAT_UNPACK_CLASSIFY_EN.
module float_fields
  import float_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int SIG_W = 23
) (
  input  logic [EXP_W+SIG_W:0] bits,
  output logic                 sign,
  output logic [EXP_W-1:0]     exponent,
  output logic [SIG_W:0]       mantissa,
`ifdef FLOAT_UNPACK_CLASSIFY_EN
  output logic [CLS_W-1:0]     cls,
`endif
  output logic [EXP_W:0]       unbiased
);
  localparam logic [EXP_W:0] BIAS = (EXP_W+1)'(bias(EXP_W));

  logic [SIG_W-1:0] significand;
  logic             exp_zero;
  logic             exp_ones;
  logic             sig_zero;

  assign sign        = bits[EXP_W+SIG_W];
  assign exponent    = bits[EXP_W+SIG_W-1:SIG_W];
  assign significand = bits[SIG_W-1:0];

  assign exp_zero = (exponent == '0);
  assign exp_ones = &exponent;
  assign sig_zero = (significand == '0);

  assign mantissa = {~exp_zero, significand};
  // Subnormals share the minimum normal exponent.
  assign unbiased = (exp_zero ? (EXP_W+1)'(1) : {1'b0, exponent}) - BIAS;

`ifdef FLOAT_UNPACK_CLASSIFY_EN
  always_comb begin
    cls           = '0;
    cls[CLS_ZERO] = exp_zero && sig_zero;
    cls[CLS_SUB]  = exp_zero && !sig_zero;
    cls[CLS_INF]  = exp_ones && sig_zero;
    cls[CLS_NAN]  = exp_ones && !sig_zero;
  end
`endif
endmodule

// File: rtl/float_unpack_queue.sv
// Unpacks floats on entry and queues the fields; 1-cycle latency, head outputs zero when empty.
// io_in_ready = not full (no path from io_out_ready); FLOAT_UNPACK_CLASSIFY_EN adds io_out_class.
module float_unpack_queue
  import float_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int SIG_W = 23,
  parameter int DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       io_flush,
  input  logic                       io_in_valid,
  output logic                       io_in_ready,
  input  logic [EXP_W+SIG_W:0]       io_in_bits,
  output logic                       io_out_valid,
  input  logic                       io_out_ready,
  output logic                       io_out_sign,
  output logic [EXP_W-1:0]           io_out_exponent,
  output logic [SIG_W-1:0]           io_out_significand,
  output logic [SIG_W:0]             io_out_mantissa,
  output logic [EXP_W:0]             io_out_unbiased,
`ifdef FLOAT_UNPACK_CLASSIFY_EN
  output logic [CLS_W-1:0]           io_out_class,
`endif
  output logic [$clog2(DEPTH+1)-1:0] io_count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exponent;
    logic [SIG_W:0]   mantissa;
    logic [EXP_W:0]   unbiased;
`ifdef FLOAT_UNPACK_CLASSIFY_EN
    logic [CLS_W-1:0] cls;
`endif
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           in_entry;
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  float_fields #(
    .EXP_W (EXP_W),
    .SIG_W (SIG_W)
  ) u_fields (
    .bits     (io_in_bits),
    .sign     (in_entry.sign),
    .exponent (in_entry.exponent),
    .mantissa (in_entry.mantissa),
`ifdef FLOAT_UNPACK_CLASSIFY_EN
    .cls      (in_entry.cls),
`endif
    .unbiased (in_entry.unbiased)
  );

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign io_in_ready  = (count < CNT_W'(DEPTH));
  assign io_out_valid = (count != '0);
  assign io_count     = count;
  assign push         = io_in_valid && io_in_ready;
  assign pop          = io_out_valid && io_out_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (io_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Payload needs no reset: the count gates every read.
  always_ff @(posedge clock) begin
    if (push && !io_flush) mem[wr_ptr] <= in_entry;
  end

  assign head = io_out_valid ? mem[rd_ptr] : '0;

  assign io_out_sign        = head.sign;
  assign io_out_exponent    = head.exponent;
  assign io_out_significand = head.mantissa[SIG_W-1:0];
  assign io_out_mantissa    = head.mantissa;
  assign io_out_unbiased    = head.unbiased;
`ifdef FLOAT_UNPACK_CLASSIFY_EN
  assign io_out_class       = head.cls;
`endif
endmodule

// File: tb/tb_float_unpack_queue.sv
// Directed bench for float_unpack_queue (EXP_W=8, SIG_W=23, DEPTH=2); class checks need FLOAT_UNPACK_CLASSIFY_EN.
module tb_float_unpack_queue;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        io_flush;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [31:0] io_in_bits;
  logic        io_out_valid;
  logic        io_out_ready;
  logic        io_out_sign;
  logic [7:0]  io_out_exponent;
  logic [22:0] io_out_significand;
  logic [23:0] io_out_mantissa;
  logic [8:0]  io_out_unbiased;
`ifdef FLOAT_UNPACK_CLASSIFY_EN
  logic [3:0]  io_out_class;
`endif
  logic [1:0]  io_count;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [8:0] UNB_M117 = 9'h18B;
  localparam logic [8:0] UNB_M126 = 9'h182;
  localparam logic [8:0] UNB_P128 = 9'h080;

  float_unpack_queue #(.EXP_W(8), .SIG_W(23), .DEPTH(2)) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .io_flush           (io_flush),
    .io_in_valid        (io_in_valid),
    .io_in_ready        (io_in_ready),
    .io_in_bits         (io_in_bits),
    .io_out_valid       (io_out_valid),
    .io_out_ready       (io_out_ready),
    .io_out_sign        (io_out_sign),
    .io_out_exponent    (io_out_exponent),
    .io_out_significand (io_out_significand),
    .io_out_mantissa    (io_out_mantissa),
    .io_out_unbiased    (io_out_unbiased),
`ifdef FLOAT_UNPACK_CLASSIFY_EN
    .io_out_class       (io_out_class),
`endif
    .io_count           (io_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cls(input string tag, input logic [3:0] exp);
`ifdef FLOAT_UNPACK_CLASSIFY_EN
    chk(tag, 64'(io_out_class), 64'(exp));
`endif
  endtask

  // Advance past the next rising edge, leaving inputs stable around it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] word);
    chk({tag, "_valid"}, 64'(io_out_valid), 64'(1));
    chk({tag, "_exp"},   64'(io_out_exponent), 64'(word[30:23]));
    chk({tag, "_sig"},   64'(io_out_significand), 64'(word[22:0]));
  endtask

  initial begin
    reset_n      = 1'b0;
    io_flush     = 1'b0;
    io_in_valid  = 1'b0;
    io_in_bits   = '0;
    io_out_ready = 1'b0;
    #2;
    chk("rst_valid", 64'(io_out_valid), 64'(0));
    chk("rst_ready", 64'(io_in_ready), 64'(1));
    chk("rst_count", 64'(io_count), 64'(0));
    chk("rst_exp",   64'(io_out_exponent), 64'(0));
    tick();
    reset_n = 1'b1;
    tick();

    // Single word into empty queue.
    io_in_valid = 1'b1;
    io_in_bits  = 32'h85000080;
    tick();
    chk("w1_valid", 64'(io_out_valid), 64'(1));
    chk("w1_sign",  64'(io_out_sign), 64'(1));
    chk("w1_exp",   64'(io_out_exponent), 64'h0A);
    chk("w1_sig",   64'(io_out_significand), 64'h000080);
    chk("w1_mant",  64'(io_out_mantissa), 64'h800080);
    chk("w1_unb",   64'(io_out_unbiased), 64'(UNB_M117));
    chk_cls("w1_cls", 4'b0000);
    chk("w1_count", 64'(io_count), 64'(1));

    // Fill, then offer a third word while full.
    io_in_bits = 32'h3F800000;
    tick();
    chk("full_count", 64'(io_count), 64'(2));
    chk("full_ready", 64'(io_in_ready), 64'(0));
    io_in_bits = 32'h40000000;
    tick();
    chk("blk_count", 64'(io_count), 64'(2));
    chk_head("blk_head", 32'h85000080);
    io_in_valid  = 1'b0;
    io_out_ready = 1'b1;
    tick();
    chk_head("drain1", 32'h3F800000);
    chk("drain1_unb",   64'(io_out_unbiased), 64'(0));
    chk("drain1_count", 64'(io_count), 64'(1));
    tick();
    chk("drain2_valid", 64'(io_out_valid), 64'(0));
    chk("drain2_count", 64'(io_count), 64'(0));
    chk("empty_sig",    64'(io_out_significand), 64'(0));
    chk("empty_mant",   64'(io_out_mantissa), 64'(0));

    // Full queue with valid and ready together: dequeue only.
    io_out_ready = 1'b0;
    io_in_valid  = 1'b1;
    io_in_bits   = 32'h40000000;
    tick();
    io_in_bits = 32'h40400000;
    tick();
    chk("f2_count", 64'(io_count), 64'(2));
    io_in_bits   = 32'h40800000;
    io_out_ready = 1'b1;
    tick();
    chk("fd_count", 64'(io_count), 64'(1));
    chk_head("fd_head", 32'h40400000);
    io_in_bits = 32'h41000000;
    tick();
    chk("st1_count", 64'(io_count), 64'(1));
    chk_head("st1_head", 32'h41000000);
    io_in_bits = 32'h41100000;
    tick();
    chk("st2_count", 64'(io_count), 64'(1));
    chk_head("st2_head", 32'h41100000);

    // Special values streamed one per cycle.
    io_in_bits = 32'h00000000;
    tick();
    chk_head("zero", 32'h00000000);
    chk("zero_mant", 64'(io_out_mantissa), 64'h000000);
    chk("zero_unb",  64'(io_out_unbiased), 64'(UNB_M126));
    chk_cls("zero_cls", 4'b0001);
    io_in_bits = 32'h00000001;
    tick();
    chk_head("sub", 32'h00000001);
    chk("sub_mant", 64'(io_out_mantissa), 64'h000001);
    chk("sub_unb",  64'(io_out_unbiased), 64'(UNB_M126));
    chk_cls("sub_cls", 4'b0010);
    io_in_bits = 32'h7F800000;
    tick();
    chk_head("inf", 32'h7F800000);
    chk("inf_mant", 64'(io_out_mantissa), 64'h800000);
    chk("inf_unb",  64'(io_out_unbiased), 64'(UNB_P128));
    chk_cls("inf_cls", 4'b0100);
    io_in_bits = 32'h7FC00000;
    tick();
    chk_head("nan", 32'h7FC00000);
    chk("nan_mant", 64'(io_out_mantissa), 64'hC00000);
    chk_cls("nan_cls", 4'b1000);
    chk("nan_count", 64'(io_count), 64'(1));
    io_in_valid = 1'b0;
    tick();
    chk("sp_drain", 64'(io_count), 64'(0));

    // Flush overrides a concurrent enqueue.
    io_out_ready = 1'b0;
    io_in_valid  = 1'b1;
    io_in_bits   = 32'h42000000;
    tick();
    io_in_bits = 32'h42400000;
    tick();
    chk("pf_count", 64'(io_count), 64'(2));
    io_flush = 1'b1;
    tick();
    chk("fl_count", 64'(io_count), 64'(0));
    chk("fl_valid", 64'(io_out_valid), 64'(0));
    chk("fl_ready", 64'(io_in_ready), 64'(1));
    io_flush = 1'b0;
    tick();
    chk("afl_head", 64'(io_out_exponent), 64'h84);
    tick();

    // Asynchronous reset mid-stream.
    io_out_ready = 1'b1;
    tick();
    chk("pr_valid", 64'(io_out_valid), 64'(1));
    #1;
    reset_n = 1'b0;
    #1;
    chk("ar_valid", 64'(io_out_valid), 64'(0));
    chk("ar_ready", 64'(io_in_ready), 64'(1));
    chk("ar_count", 64'(io_count), 64'(0));
    chk("ar_exp",   64'(io_out_exponent), 64'(0));
    chk("ar_mant",  64'(io_out_mantissa), 64'(0));
    io_in_valid = 1'b0;
    #1;
    reset_n = 1'b1;
    tick();
    chk("post_valid", 64'(io_out_valid), 64'(0));
    chk("post_count", 64'(io_count), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/float_unpack_queue.md
FLOAT_UNPACK_QUEUE -- requirements
Module: float_unpack_queue

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width (2..15).
REQ-002 SHALL have parameter SIG_W, default 23, significand field width (1..52).
REQ-003 SHALL have parameter DEPTH, default 2, queue entries (1..16).
REQ-004 SHALL have ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low.
- io_flush  in  1  synchronous queue clear.
- io_in_valid  in  1  producer valid.
- io_in_ready  out  1  queue can accept.
- io_in_bits  in  1+EXP_W+SIG_W  packed float {sign, exponent, significand}.
- io_out_valid  out  1  head entry valid.
- io_out_ready  in  1  consumer ready.
- io_out_sign  out  1  head sign.
- io_out_exponent  out  EXP_W  head raw exponent.
- io_out_significand  out  SIG_W  head raw significand.
- io_out_mantissa  out  SIG_W+1  significand with hidden bit.
- io_out_unbiased  out  EXP_W+1  signed unbiased exponent.
- io_out_class  out  4  {nan, inf, subnormal, zero} (only with macro, REQ-019).
- io_count  out  clog2(DEPTH+1)  occupied entries.

Function
REQ-005 Enqueue SHALL occur on a rising clock edge when io_in_valid && io_in_ready; dequeue when io_out_valid && io_out_ready.
REQ-006 io_in_ready SHALL equal (io_count < DEPTH), with no combinational path from io_out_ready.
REQ-007 io_out_valid SHALL equal (io_count != 0); io_out_* fields SHALL be all zeros when empty.
REQ-008 Latency SHALL be 1 cycle: a word enqueued at edge N is presented at head after edge N when the queue was empty.
REQ-009 Order SHALL be FIFO; head and tail pointers SHALL wrap modulo DEPTH, including when DEPTH is not a power of two.
REQ-010 Simultaneous enqueue and dequeue on a non-empty, non-full queue SHALL leave io_count unchanged.
REQ-011 When full, enqueue SHALL be blocked even if a dequeue occurs in the same cycle.
REQ-012 io_flush SHALL empty the queue at the next edge, overriding enqueue and dequeue in that cycle.
REQ-013 Field split SHALL be sign = bits[EXP_W+SIG_W], exponent = next EXP_W bits, significand = low SIG_W bits; fields SHALL be computed before storage, so head outputs are register-driven.
REQ-014 io_out_mantissa SHALL be {exponent != 0, significand}.
REQ-015 io_out_unbiased SHALL be exponent - (2^(EXP_W-1) - 1) in two's complement, or 1 - bias when exponent == 0.

Reset
REQ-016 reset_n low SHALL asynchronously clear both pointers and io_count to 0, so io_out_valid = 0 and io_in_ready = 1.
REQ-017 Storage contents SHALL not require reset.
REQ-018 Reset asserted mid-transfer SHALL discard all entries; no partial word SHALL appear after release.

Configuration
REQ-019 Macro FLOAT_UNPACK_CLASSIFY_EN defined: io_out_class SHALL exist, be stored per entry, and encode:
- zero = exp 0 and sig 0.
- subnormal = exp 0 and sig != 0.
- inf = exp all-ones and sig 0.
- nan = exp all-ones and sig != 0.
- Bits SHALL be one-hot or all zero (normal); all zero when empty.
REQ-020 Macro undefined: io_out_class and its storage SHALL be absent; all other behaviour SHALL be unchanged.

Structure
REQ-021 A shared package float_pkg SHALL hold:
- the field-split typedef, parameterised by width;
- the bias function;
- the class-bit index constants.
REQ-022 One sub-module, float_fields, SHALL implement the combinational split, hidden bit, unbiased exponent and optional class; storage and control SHALL live in float_unpack_queue.

Verification (EXP_W=8, SIG_W=23, DEPTH=2)
REQ-023 Enqueue 0x85000080 into empty queue, io_out_ready=0 -> next cycle:
- io_out_valid=1, sign=1, exponent=0x0A, significand=0x000080;
- mantissa=0x800080, unbiased=-117, class=0.
REQ-024 Enqueue 3 words with io_out_ready=0 -> io_count=2, io_in_ready=0, third word not accepted; drain -> first two words in order.
REQ-025 Full queue, io_in_valid=1 and io_out_ready=1 in one cycle -> io_count 2->1, no enqueue; continuous streaming at count 1 -> one word per cycle, count stays 1.
REQ-026 Enqueue the following and check class bits and unbiased exponent:
- 0x00000000 -> zero;
- 0x00000001 -> subnormal, unbiased=-126;
- 0x7F800000 -> inf;
- 0x7FC00000 -> nan.
REQ-027 Two entries queued, then:
- io_flush with io_in_valid=1 -> io_count=0 next cycle;
- reset_n pulsed low mid-stream -> outputs immediately zero and io_in_ready=1.
